// File: rtl/ex_muldiv_unit.sv
// RV32M multiply/divide execute unit: iterative shift-add / restoring divide, BITS_PER_CYCLE bits per cycle.
// Latency XLEN/BITS_PER_CYCLE cycles (1 for div-by-zero/overflow); result held in DONE until out_ready, flush kills.
module ex_muldiv_unit #(
  parameter int XLEN           = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      in_func3,
  input  logic [XLEN-1:0] in_rs1,
  input  logic [XLEN-1:0] in_rs2,
  input  logic [4:0]      in_rd_addr,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic [4:0]      out_rd_addr,
  output logic            out_reg_write,
  output logic            busy
);

  localparam int STEPS = XLEN / BITS_PER_CYCLE;
  localparam int CNT_W = $clog2(STEPS) + 1;
  localparam int AW    = 2 * XLEN + 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e            state_q;
  logic [2:0]        func3_q;
  logic [4:0]        rd_q;
  logic [XLEN-1:0]   b_q;
  logic              neg_q;
  logic              special_q;
  logic [XLEN-1:0]   special_res_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [AW-1:0]     acc_q;
  logic [AW-1:0]     acc_d;
  logic [XLEN-1:0]   result_q;

  // Operand conditioning at acceptance
  logic            a_sgn, b_sgn, a_neg, b_neg, res_neg;
  logic [XLEN-1:0] a_abs, b_abs, spec_res;
  logic            is_div, div_zero, div_ovf, special;

  always_comb begin
    is_div   = in_func3[2];
    a_sgn    = (in_func3 != 3'b011) && (in_func3 != 3'b101) && (in_func3 != 3'b111);
    b_sgn    = a_sgn && (in_func3 != 3'b010);
    a_neg    = a_sgn && in_rs1[XLEN-1];
    b_neg    = b_sgn && in_rs2[XLEN-1];
    a_abs    = a_neg ? -in_rs1 : in_rs1;
    b_abs    = b_neg ? -in_rs2 : in_rs2;
    // Remainder takes the dividend's sign; everything else the product/quotient sign
    res_neg  = (in_func3 == 3'b110) ? a_neg : (a_neg ^ b_neg);
    div_zero = is_div && (in_rs2 == '0);
    div_ovf  = is_div && !in_func3[0] && (in_rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (in_rs2 == '1);
    special  = div_zero || div_ovf;
    if (div_zero) spec_res = in_func3[1] ? in_rs1 : '1;
    else          spec_res = in_func3[1] ? '0 : in_rs1;
  end

  // One iteration step: acc = {hi[XLEN:0], lo[XLEN-1:0]}, lo starts as |rs1|
  logic [XLEN+1:0] trial;

  always_comb begin
    acc_d = acc_q;
    trial = '0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      if (!func3_q[2]) begin
        if (acc_d[0]) acc_d[AW-1:XLEN] = acc_d[AW-1:XLEN] + {1'b0, b_q};
        acc_d = acc_d >> 1;
      end else begin
        acc_d = acc_d << 1;
        trial = {1'b0, acc_d[AW-1:XLEN]} - {2'b00, b_q};
        if (!trial[XLEN+1]) begin
          acc_d[AW-1:XLEN] = trial[XLEN:0];
          acc_d[0]         = 1'b1;
        end
      end
    end
  end

  logic [2*XLEN-1:0] prod_c;
  logic [XLEN-1:0]   dsel, dsel_c, calc_res;

  always_comb begin
    prod_c = neg_q ? -acc_d[2*XLEN-1:0] : acc_d[2*XLEN-1:0];
    dsel   = func3_q[1] ? acc_d[2*XLEN-1:XLEN] : acc_d[XLEN-1:0];
    dsel_c = neg_q ? -dsel : dsel;
    if (special_q)              calc_res = special_res_q;
    else if (func3_q[2])        calc_res = dsel_c;
    else if (func3_q == 3'b000) calc_res = prod_c[XLEN-1:0];
    else                        calc_res = prod_c[2*XLEN-1:XLEN];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      func3_q       <= '0;
      rd_q          <= '0;
      b_q           <= '0;
      neg_q         <= 1'b0;
      special_q     <= 1'b0;
      special_res_q <= '0;
      cnt_q         <= '0;
      acc_q         <= '0;
      result_q      <= '0;
    end else if (flush) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            func3_q       <= in_func3;
            rd_q          <= in_rd_addr;
            b_q           <= b_abs;
            acc_q         <= {{(XLEN+1){1'b0}}, a_abs};
            neg_q         <= res_neg;
            special_q     <= special;
            special_res_q <= spec_res;
            cnt_q         <= special ? CNT_W'(1) : CNT_W'(STEPS);
            state_q       <= CALC;
          end
        end
        CALC: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            result_q <= calc_res;
            state_q  <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready      = (state_q == IDLE);
  assign out_valid     = (state_q == DONE);
  assign busy          = (state_q != IDLE);
  assign out_result    = result_q;
  assign out_rd_addr   = rd_q;
  assign out_reg_write = out_valid && (rd_q != 5'd0);

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Bench for ex_muldiv_unit: directed RV32M cases plus random ops on BITS_PER_CYCLE=1 and =4 instances.
module tb_ex_muldiv_unit;

  logic        clk;
  logic        rst_n;
  logic        in_valid  [2];
  logic        in_ready  [2];
  logic [2:0]  func3     [2];
  logic [31:0] rs1       [2];
  logic [31:0] rs2       [2];
  logic [4:0]  rd_addr   [2];
  logic        flush     [2];
  logic        out_valid [2];
  logic        out_ready [2];
  logic [31:0] out_result[2];
  logic [4:0]  out_rd    [2];
  logic        reg_write [2];
  logic        busy      [2];

  int n_tests = 0;
  int n_fail  = 0;

  ex_muldiv_unit #(.XLEN(32), .BITS_PER_CYCLE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_func3(func3[0]), .in_rs1(rs1[0]), .in_rs2(rs2[0]), .in_rd_addr(rd_addr[0]),
    .flush(flush[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_result(out_result[0]), .out_rd_addr(out_rd[0]), .out_reg_write(reg_write[0]),
    .busy(busy[0])
  );

  ex_muldiv_unit #(.XLEN(32), .BITS_PER_CYCLE(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_func3(func3[1]), .in_rs1(rs1[1]), .in_rs2(rs2[1]), .in_rd_addr(rd_addr[1]),
    .flush(flush[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_result(out_result[1]), .out_rd_addr(out_rd[1]), .out_reg_write(reg_write[1]),
    .busy(busy[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: RV32M semantics straight from 64-bit arithmetic
  function automatic logic [31:0] ref_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, ub, r;
    logic [63:0] up;
    sa = $signed(a);
    sb = $signed(b);
    ub = {32'b0, b};
    case (f)
      3'd0: begin r = sa * sb; return r[31:0]; end
      3'd1: begin r = sa * sb; return r[63:32]; end
      3'd2: begin r = sa * ub; return r[63:32]; end
      3'd3: begin up = {32'b0, a} * {32'b0, b}; return up[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        r = sa / sb; return r[31:0];
      end
      3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        r = sa % sb; return r[31:0];
      end
      default: return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(0, 255));
      default: return $urandom;
    endcase
  endfunction

  task automatic do_op(input int s, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic [31:0] exp, input bit hold);
    int  lat, k, explat;
    bit  special;
    special = f[2] && (b == 32'd0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    explat  = special ? 1 : ((s == 0) ? 32 : 8);
    k = 0;
    while (!in_ready[s] && k < 100) begin @(posedge clk); #1; k++; end
    chk("in_ready_before_issue", 32'(in_ready[s]), 32'd1);
    out_ready[s] = !hold;
    in_valid[s]  = 1'b1;
    func3[s]     = f;
    rs1[s]       = a;
    rs2[s]       = b;
    rd_addr[s]   = rd;
    @(posedge clk); #1;
    in_valid[s] = 1'b0;
    lat = 0;
    while (!out_valid[s] && lat < 100) begin @(posedge clk); #1; lat++; end
    chk("latency", 32'(lat), 32'(explat));
    chk("result", out_result[s], exp);
    chk("rd_addr", 32'(out_rd[s]), 32'(rd));
    chk("reg_write", 32'(reg_write[s]), 32'(rd != 5'd0));
    chk("in_ready_done", 32'(in_ready[s]), 32'd0);
    if (hold) begin
      repeat (10) begin
        @(posedge clk); #1;
        chk("hold_valid", 32'(out_valid[s]), 32'd1);
        chk("hold_result", out_result[s], exp);
        chk("hold_in_ready", 32'(in_ready[s]), 32'd0);
      end
      out_ready[s] = 1'b1;
    end
    @(posedge clk); #1;
    chk("handoff_valid", 32'(out_valid[s]), 32'd0);
    chk("handoff_in_ready", 32'(in_ready[s]), 32'd1);
  endtask

  logic [2:0]  vf [12] = '{3'd0, 3'd3, 3'd1, 3'd4, 3'd6, 3'd5, 3'd7, 3'd5, 3'd6, 3'd4, 3'd6, 3'd2};
  logic [31:0] va [12] = '{32'd7, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100,
                           32'd100, 32'h0001_2345, 32'd5, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF};
  logic [31:0] vb [12] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h8000_0000, 32'd2, 32'd2, 32'd7,
                           32'd7, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
  logic [31:0] ve [12] = '{32'hFFFF_FFEB, 32'hFFFF_FFFE, 32'h4000_0000, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14,
                           32'd2, 32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0, 32'hFFFF_FFFF};

  initial begin
    bit          seen;
    logic [2:0]  rf;
    logic [31:0] ra, rb;
    rst_n = 1'b0;
    for (int s = 0; s < 2; s++) begin
      in_valid[s] = 1'b0; func3[s] = '0; rs1[s] = '0; rs2[s] = '0;
      rd_addr[s] = '0; flush[s] = 1'b0; out_ready[s] = 1'b1;
    end
    #2;
    for (int s = 0; s < 2; s++) begin
      chk("rst_in_ready", 32'(in_ready[s]), 32'd1);
      chk("rst_out_valid", 32'(out_valid[s]), 32'd0);
      chk("rst_result", out_result[s], 32'd0);
      chk("rst_rd", 32'(out_rd[s]), 32'd0);
      chk("rst_reg_write", 32'(reg_write[s]), 32'd0);
      chk("rst_busy", 32'(busy[s]), 32'd0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int s = 0; s < 2; s++)
      for (int i = 0; i < 12; i++)
        do_op(s, vf[i], va[i], vb[i], 5'(i + 1), ve[i], 1'b0);

    do_op(0, 3'd5, 32'd100, 32'd7, 5'd0, 32'd14, 1'b1);
    do_op(1, 3'd0, 32'd9, 32'd9, 5'd3, 32'd81, 1'b1);

    // Flush in IDLE blocks acceptance
    in_valid[0] = 1'b1; flush[0] = 1'b1; func3[0] = 3'd0; rs1[0] = 32'd3; rs2[0] = 32'd3;
    @(posedge clk); #1;
    in_valid[0] = 1'b0; flush[0] = 1'b0;
    chk("idle_flush_busy", 32'(busy[0]), 32'd0);
    chk("idle_flush_in_ready", 32'(in_ready[0]), 32'd1);

    // Flush at CALC cycle 5
    in_valid[0] = 1'b1; func3[0] = 3'd0; rs1[0] = 32'd11; rs2[0] = 32'd13; rd_addr[0] = 5'd4;
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    flush[0] = 1'b1;
    @(posedge clk); #1;
    flush[0] = 1'b0;
    chk("calc_flush_in_ready", 32'(in_ready[0]), 32'd1);
    chk("calc_flush_valid", 32'(out_valid[0]), 32'd0);
    seen = 1'b0;
    repeat (40) begin @(posedge clk); #1; if (out_valid[0]) seen = 1'b1; end
    chk("calc_flush_no_valid", 32'(seen), 32'd0);
    do_op(0, 3'd0, 32'd3, 32'd4, 5'd5, 32'd12, 1'b0);

    // Flush beats out_ready in DONE
    out_ready[1] = 1'b0;
    in_valid[1] = 1'b1; func3[1] = 3'd5; rs1[1] = 32'd50; rs2[1] = 32'd0; rd_addr[1] = 5'd6;
    @(posedge clk); #1;
    in_valid[1] = 1'b0;
    @(posedge clk); #1;
    chk("done_before_flush", 32'(out_valid[1]), 32'd1);
    flush[1] = 1'b1; out_ready[1] = 1'b1;
    @(posedge clk); #1;
    flush[1] = 1'b0;
    chk("done_flush_valid", 32'(out_valid[1]), 32'd0);
    chk("done_flush_in_ready", 32'(in_ready[1]), 32'd1);

    // Async reset mid-CALC
    in_valid[0] = 1'b1; func3[0] = 3'd4; rs1[0] = 32'd1000; rs2[0] = 32'd7; rd_addr[0] = 5'd9;
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready", 32'(in_ready[0]), 32'd1);
    chk("mid_rst_valid", 32'(out_valid[0]), 32'd0);
    chk("mid_rst_result", out_result[0], 32'd0);
    chk("mid_rst_rd", 32'(out_rd[0]), 32'd0);
    chk("mid_rst_busy", 32'(busy[0]), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (40) begin @(posedge clk); #1; if (out_valid[0] || out_valid[1]) seen = 1'b1; end
    chk("post_rst_no_valid", 32'(seen), 32'd0);

    // Random ops against the reference model
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < 150; i++) begin
        rf = 3'($urandom_range(0, 7));
        ra = pick();
        rb = pick();
        do_op(s, rf, ra, rb, 5'($urandom_range(0, 31)), ref_op(rf, ra, rb), 1'b0);
      end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
